// File: rtl/moore_seq_detector_pkg.sv
// Shared types for the serial pattern detector: FSM state encoding and width.
package moore_seq_detector_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        DETECT = 2'd2
    } state_e;

endpackage

// File: rtl/moore_seq_detector_if.sv
// Control/data bundle between a serial bit source and the pattern detector.
interface moore_seq_detector_if #(
    parameter int unsigned PATTERN_LEN = 4,
    parameter int unsigned CNT_W       = 8
);
    logic                   en;
    logic                   din_valid;
    logic                   din;
    logic [PATTERN_LEN-1:0] pattern;
    logic                   overlap;
    logic                   cnt_clr;
    logic                   y;
    logic [CNT_W-1:0]       match_count;
    logic                   busy;

    modport master (
        output en, din_valid, din, pattern, overlap, cnt_clr,
        input  y, match_count, busy
    );

    modport slave (
        input  en, din_valid, din, pattern, overlap, cnt_clr,
        output y, match_count, busy
    );
endinterface

// File: rtl/moore_seq_detector_sat_counter.sv
// Saturating up-counter; a clear on the same edge as an increment yields 1.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    localparam logic [W-1:0] MAX = '1;

    logic [W-1:0] base;

    always_comb begin
        base = clr ? '0 : q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (inc && (base != MAX)) begin
            q <= base + W'(1);
        end else begin
            q <= base;
        end
    end
endmodule

// File: rtl/moore_seq_detector.sv
// Moore serial pattern detector with programmable pattern, overlap select and match counter.
module moore_seq_detector
    import moore_seq_detector_pkg::*;
#(
    parameter int unsigned PATTERN_LEN = 4,
    parameter int unsigned CNT_W       = 8
) (
    input logic                 clk,
    input logic                 rst,
    moore_seq_detector_if.slave bus
);
    localparam int unsigned FILL_W = $clog2(PATTERN_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_LEN);

    state_e                 state, state_n;
    logic [PATTERN_LEN-1:0] hist, hist_n, hist_sh;
    logic [PATTERN_LEN-1:0] pat_q, pat_n;
    logic [FILL_W-1:0]      fill, fill_n, fill_inc;
    logic                   match;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hist     <= '0;
            fill     <= '0;
            pat_q    <= '0;
            bus.y    <= 1'b0;
            bus.busy <= 1'b0;
        end else begin
            state    <= state_n;
            hist     <= hist_n;
            fill     <= fill_n;
            pat_q    <= pat_n;
            bus.y    <= (state_n == DETECT);
            bus.busy <= (state_n != IDLE);
        end
    end

    // Match is judged on the post-shift history and fill, so y follows the final bit by one edge.
    always_comb begin
        state_n  = state;
        hist_n   = hist;
        fill_n   = fill;
        pat_n    = pat_q;
        match    = 1'b0;
        hist_sh  = {hist[PATTERN_LEN-2:0], bus.din};
        fill_inc = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);

        if (!bus.en) begin
            state_n = IDLE;
            hist_n  = '0;
            fill_n  = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_n = ARMED;
                    pat_n   = bus.pattern;
                end
                default: begin
                    state_n = ARMED;
                    if (bus.din_valid) begin
                        hist_n = hist_sh;
                        fill_n = fill_inc;
                        if ((fill_inc == FILL_FULL) && (hist_sh == pat_q)) begin
                            match   = 1'b1;
                            state_n = DETECT;
                            fill_n  = bus.overlap ? FILL_FULL : '0;
                        end
                    end
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (bus.cnt_clr),
        .inc (match),
        .q   (bus.match_count)
    );
endmodule

// File: tb/tb_moore_seq_detector.sv
// Directed bench: each edge's expected y/busy/match_count is queued and checked by a monitor.
module tb_moore_seq_detector;
    localparam int unsigned PL = 4;
    localparam int unsigned CW = 2;

    typedef struct packed {
        logic          y;
        logic          busy;
        logic [CW-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    always #5 clk = ~clk;

    moore_seq_detector_if #(.PATTERN_LEN(PL), .CNT_W(CW)) bus ();

    moore_seq_detector #(.PATTERN_LEN(PL), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Drive one edge's inputs, then queue what the outputs must show after that edge.
    task automatic step(input string nm, input int v, input int d,
                        input int ey, input int eb, input int ec);
        exp_t e;
        bus.din_valid = 1'(v);
        bus.din       = 1'(d);
        @(posedge clk);
        #1;
        e.y    = 1'(ey);
        e.busy = 1'(eb);
        e.cnt  = CW'(ec);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    always @(negedge clk) begin
        exp_t  e;
        string nm;
        if (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_checks++;
            if ((bus.y !== e.y) || (bus.busy !== e.busy) || (bus.match_count !== e.cnt)) begin
                n_fail++;
                $display("FAIL %s: got y=%b busy=%b cnt=%0d, want y=%b busy=%b cnt=%0d",
                         nm, bus.y, bus.busy, bus.match_count, e.y, e.busy, e.cnt);
            end
        end
    end

    initial begin
        rst           = 1'b1;
        bus.en        = 1'b0;
        bus.din_valid = 1'b0;
        bus.din       = 1'b0;
        bus.pattern   = 4'b1011;
        bus.overlap   = 1'b1;
        bus.cnt_clr   = 1'b0;

        // Reset, then a 3-bit partial match interrupted by a 2-edge reset
        step("reset", 0, 0, 0, 0, 0);
        rst = 1'b0; bus.en = 1'b1;
        step("arm0", 0, 0, 0, 1, 0);
        step("part1", 1, 1, 0, 1, 0);
        step("part2", 1, 0, 0, 1, 0);
        step("part3", 1, 1, 0, 1, 0);
        rst = 1'b1;
        step("rst_mid1", 1, 1, 0, 0, 0);
        step("rst_mid2", 1, 1, 0, 0, 0);
        rst = 1'b0;
        step("rearm", 0, 0, 0, 1, 0);
        step("nopat1", 1, 1, 0, 1, 0);
        step("nopat2", 1, 0, 0, 1, 0);
        step("nopat3", 1, 0, 0, 1, 0);
        step("nopat4", 1, 1, 0, 1, 0);

        // Overlapping detection of 1011 in 1011011
        bus.en = 1'b0;
        step("ov_idle", 0, 0, 0, 0, 0);
        bus.en = 1'b1;
        step("ov_arm", 0, 0, 0, 1, 0);
        step("ov_b1", 1, 1, 0, 1, 0);
        step("ov_b2", 1, 0, 0, 1, 0);
        step("ov_b3", 1, 1, 0, 1, 0);
        step("ov_b4", 1, 1, 1, 1, 1);
        step("ov_b5", 1, 0, 0, 1, 1);
        step("ov_b6", 1, 1, 0, 1, 1);
        step("ov_b7", 1, 1, 1, 1, 2);
        step("ov_gap", 0, 0, 0, 1, 2);
        bus.cnt_clr = 1'b1;
        step("ov_clr", 0, 0, 0, 1, 0);
        bus.cnt_clr = 1'b0;

        // Non-overlapping: second occurrence shares bits, so it is not counted
        bus.en = 1'b0; bus.overlap = 1'b0;
        step("no_idle", 0, 0, 0, 0, 0);
        bus.en = 1'b1;
        step("no_arm", 0, 0, 0, 1, 0);
        step("no_b1", 1, 1, 0, 1, 0);
        step("no_b2", 1, 0, 0, 1, 0);
        step("no_b3", 1, 1, 0, 1, 0);
        step("no_b4", 1, 1, 1, 1, 1);
        step("no_b5", 1, 0, 0, 1, 1);
        step("no_b6", 1, 1, 0, 1, 1);
        step("no_b7", 1, 1, 0, 1, 1);
        step("no_gap", 0, 0, 0, 1, 1);
        bus.cnt_clr = 1'b1;
        step("no_clr", 0, 0, 0, 1, 0);
        bus.cnt_clr = 1'b0;

        // Valid gaps with junk din, and a pattern change while busy
        bus.en = 1'b0; bus.overlap = 1'b1;
        step("vg_idle", 0, 0, 0, 0, 0);
        bus.en = 1'b1;
        step("vg_arm", 0, 0, 0, 1, 0);
        bus.pattern = 4'b0000;
        step("vg_b1", 1, 1, 0, 1, 0);
        step("vg_b2", 1, 0, 0, 1, 0);
        step("vg_gap1", 0, 1, 0, 1, 0);
        step("vg_gap2", 0, 1, 0, 1, 0);
        step("vg_gap3", 0, 1, 0, 1, 0);
        step("vg_b3", 1, 1, 0, 1, 0);
        step("vg_b4", 1, 1, 1, 1, 1);
        step("vg_z1", 1, 0, 0, 1, 1);
        step("vg_z2", 1, 0, 0, 1, 1);
        step("vg_z3", 1, 0, 0, 1, 1);
        step("vg_z4", 1, 0, 0, 1, 1);
        bus.cnt_clr = 1'b1;
        step("vg_clr", 0, 0, 0, 1, 0);
        bus.cnt_clr = 1'b0;

        // Back-to-back detections of 1111 and counter saturation at 3
        bus.en = 1'b0; bus.pattern = 4'b1111;
        step("sat_idle", 0, 0, 0, 0, 0);
        bus.en = 1'b1;
        step("sat_arm", 0, 0, 0, 1, 0);
        step("sat_b1", 1, 1, 0, 1, 0);
        step("sat_b2", 1, 1, 0, 1, 0);
        step("sat_b3", 1, 1, 0, 1, 0);
        step("sat_b4", 1, 1, 1, 1, 1);
        step("sat_b5", 1, 1, 1, 1, 2);
        step("sat_b6", 1, 1, 1, 1, 3);
        step("sat_b7", 1, 1, 1, 1, 3);
        step("sat_b8", 1, 1, 1, 1, 3);
        step("sat_b9", 1, 1, 1, 1, 3);
        step("sat_b10", 1, 1, 1, 1, 3);
        step("sat_gap", 0, 0, 0, 1, 3);

        // Clear coincident with a match gives 1
        bus.cnt_clr = 1'b1;
        step("clr_hit", 1, 1, 1, 1, 1);
        bus.cnt_clr = 1'b0;

        // en drop mid-pattern discards the partial match; count survives
        bus.en = 1'b0; bus.pattern = 4'b1011;
        step("en_idle", 0, 0, 0, 0, 1);
        bus.en = 1'b1;
        step("en_arm", 0, 0, 0, 1, 1);
        step("en_p1", 1, 1, 0, 1, 1);
        step("en_p2", 1, 0, 0, 1, 1);
        bus.en = 1'b0;
        step("en_drop", 1, 1, 0, 0, 1);
        bus.en = 1'b1;
        step("en_rearm", 0, 0, 0, 1, 1);
        step("en_n1", 1, 1, 0, 1, 1);
        step("en_n2", 1, 1, 0, 1, 1);
        step("en_n3", 1, 1, 0, 1, 1);
        step("en_n4", 1, 0, 0, 1, 1);
        step("en_n5", 1, 1, 0, 1, 1);
        step("en_n6", 1, 1, 1, 1, 2);
        step("en_end", 0, 0, 0, 1, 2);

        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/moore_seq_detector.md
Name: moore_seq_detector

Overview:
- Parametrised successor to the two-state JK Moore machine: a Moore-style serial pattern detector with a programmable pattern of PATTERN_LEN bits.
- Selectable overlapping or non-overlapping detection, a qualifying valid input, and a saturating match counter.
- Sits on a serial bit stream; `y` is a registered, state-derived pulse that depends only on the current state.

Parameters:
- PATTERN_LEN, 4, pattern length in bits (2..32).
- CNT_W, 8, width of the saturating match counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset; one clock, sampled on the rising edge of clk.
- en  input  1  detector enable; 0 forces the IDLE state.
- din_valid  input  1  qualifies din for the current cycle.
- din  input  1  serial data bit.
- pattern  input  PATTERN_LEN  target pattern; pattern[PATTERN_LEN-1] is the first bit received.
- overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- cnt_clr  input  1  clears match_count.
- y  output  1  detect pulse (Moore output: high only in state DETECT).
- match_count  output  CNT_W  number of detections, saturating at all-ones.
- busy  output  1  high in ARMED or DETECT.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, hist=0, fill=0, pat_q=0, match_count=0, y=0, busy=0. Reset overrides all other inputs, including during a partial match.
- States:
  - IDLE: y=0, busy=0.
  - ARMED: filling or comparing; y=0, busy=1.
  - DETECT: y=1, busy=1.
- IDLE -> ARMED on an edge with en=1; pattern is captured into pat_q on that edge. pattern changes while busy are ignored until the block returns to IDLE.
- In ARMED or DETECT, each edge with din_valid=1 does the following:
  - hist <= {hist[PATTERN_LEN-2:0], din}.
  - fill <= min(fill+1, PATTERN_LEN).
- Match condition, evaluated on next-state values: next fill == PATTERN_LEN and next hist == pat_q. On a match:
  - state <= DETECT.
  - match_count increments.
  - fill <= PATTERN_LEN if overlap=1, else 0 (non-overlap requires PATTERN_LEN fresh bits).
- Otherwise, from ARMED or DETECT, state <= ARMED.
- Edges with din_valid=0 hold hist and fill; DETECT -> ARMED on such an edge.
- y is therefore a single-cycle pulse per match. Back-to-back DETECT cycles are possible with overlap=1 (e.g. pattern 1111, stream of 1s).
- Latency: y rises in the clock cycle immediately following the edge that consumed the final pattern bit; no combinational path from din to y.
- en=0 on any edge: state <= IDLE, hist <= 0, fill <= 0. match_count is retained. en has priority below rst and above din_valid.
- match_count:
  - Saturates at 2^CNT_W-1 with no wrap.
  - cnt_clr alone -> 0.
  - cnt_clr coincident with a match -> 1 (clear, then count).
- overlap is sampled live on each match edge and is not latched.
- Widths: fill is clog2(PATTERN_LEN+1) bits; hist and pat_q are PATTERN_LEN bits.

Decomposition:
- Shared package: state enum (IDLE=2'd0, ARMED=2'd1, DETECT=2'd2) and the state width constant.
- One sub-module, sat_counter (parameter W; inputs clk, rst, clr, inc; output q): clear-then-increment semantics and saturation. All else stays in the top level.

Test Plan:
- Reset: hold rst=1 for 2 edges mid-stream after a partial match of 3 bits -> y=0, busy=0, match_count=0. After release, with en=1, a 4-bit stream without the pattern -> no detect.
- Overlap: PATTERN_LEN=4, pattern=4'b1011, overlap=1, serial 1,0,1,1,0,1,1 all valid -> y pulses one cycle after bit 4 and one cycle after bit 7; match_count=2.
- Non-overlap: same stimulus with overlap=0 -> single y pulse after bit 4; match_count=1.
- Valid gaps: same pattern, din_valid deasserted for 3 cycles between bits 2 and 3 -> y still pulses exactly once, one cycle after the 4th valid bit. Pattern changed to 4'b0000 mid-stream -> ignored.
- Back-to-back and saturation: CNT_W=2, pattern=4'b1111, overlap=1, ten valid 1s -> y high for 7 consecutive cycles; match_count holds at 3.
- Counter clear collision: cnt_clr asserted on the same edge as a match -> match_count=1. en dropped mid-pattern, then re-raised -> requires a full 4 new bits; match_count unchanged across en toggling.
